// File: rtl/cbg_sp_ram.sv
// Parametrised single-port RAM with byte enables, write acknowledge and a one-word-per-cycle clear sweep.
// Define SP_RAM_OUTREG_EN to add an output pipeline stage (read latency 2).
`ifndef RAM_DEEP
`define RAM_DEEP 512
`endif

module cbg_sp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = `RAM_DEEP,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [BE_W-1:0]   be,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              read_valid,
  output logic              write_valid,
  output logic              busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_nx;
  logic [DATA_W-1:0]   ram [DEPTH];

  logic                in_range, req_ok, rd_req, wr_req;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [BE_W-1:0]     wr_be;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid, wr_valid;

  assign in_range = {1'b0, addr} < DEPTH_X;
  assign req_ok   = (state == IDLE) & ena & ~flush;
  assign rd_req   = req_ok & ~wea;
  assign wr_req   = req_ok & wea;
  assign busy     = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    if (flush) begin
      state_nx    = CLEAR;
      clr_addr_nx = '0;
    end else if (state == CLEAR) begin
      clr_addr_nx = clr_addr + 1'b1;
      if (clr_addr == LAST) state_nx = IDLE;
    end
  end

  // One shared write port: the sweep owns it while clearing, otherwise in-range accepted writes.
  // Gated by rst_n so that clock edges during reset leave the array untouched.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr;
    wr_be   = be;
    wr_data = din;
    if (state == CLEAR) begin
      wr_en   = rst_n;
      wr_addr = clr_addr;
      wr_be   = '1;
      wr_data = '0;
    end else if (wr_req && in_range) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr_be[k]) ram[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '1;
      rd_valid <= 1'b0;
      wr_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      wr_valid <= wr_req;
      if (flush) rd_data <= '1;
      else if (rd_req) rd_data <= in_range ? ram[addr] : '1;
    end
  end

  assign write_valid = wr_valid;

`ifdef SP_RAM_OUTREG_EN
  // Second stage keeps data and valid aligned; flush kills anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '1;
      read_valid <= 1'b0;
    end else if (flush) begin
      dout       <= '1;
      read_valid <= 1'b0;
    end else begin
      dout       <= rd_data;
      read_valid <= rd_valid;
    end
  end
`else
  assign dout       = rd_data;
  assign read_valid = rd_valid;
`endif

endmodule
